// File: rtl/mips_fetch_pkg.sv
// Shared types, constants and address-field width helpers for the fetch stage.
package mips_fetch_pkg;

    typedef enum logic [0:0] {
        IDLE,
        REFILL
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR  = 32'h0;
    localparam int unsigned WORD_BYTES = 4;

    function automatic int unsigned off_width(int unsigned words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int unsigned idx_width(int unsigned lines);
        return $clog2(lines);
    endfunction

    // Tag takes every PC bit above the byte, offset and index fields.
    function automatic int unsigned tag_width(int unsigned lines, int unsigned words_per_line);
        return 32 - $clog2(WORD_BYTES) - $clog2(words_per_line) - $clog2(lines);
    endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped instruction cache storage: valid bits, tags and data words.
module icache_array
    import mips_fetch_pkg::*;
#(
    parameter int unsigned LINES          = 16,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned IDX_W          = idx_width(LINES),
    parameter int unsigned OFF_W          = off_width(WORDS_PER_LINE),
    parameter int unsigned TAG_W          = tag_width(LINES, WORDS_PER_LINE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_index,
    input  logic [OFF_W-1:0] rd_offset,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [OFF_W-1:0] wr_offset,
    input  logic [31:0]      wr_data,
    input  logic             install,
    input  logic [TAG_W-1:0] install_tag
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES*WORDS_PER_LINE];

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[{rd_index, rd_offset}];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (install) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tag and data contents are don't-care until the valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[{wr_index, wr_offset}] <= wr_data;
        end
        if (install) begin
            tag_mem[wr_index] <= install_tag;
        end
    end

endmodule

// File: rtl/icache_fetch.sv
// Instruction-fetch stage: PC register, direct-mapped cache lookup and line refill FSM.
module icache_fetch
    import mips_fetch_pkg::*;
#(
    parameter int unsigned LINES          = 16,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter logic [31:0] RESET_PC       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ins,
    output logic [31:0] pc_out,
    output logic        hit,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid
);

    localparam int unsigned IDX_W = idx_width(LINES);
    localparam int unsigned OFF_W = off_width(WORDS_PER_LINE);
    localparam int unsigned TAG_W = tag_width(LINES, WORDS_PER_LINE);
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

    fetch_state_t     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [OFF_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [31:0]      pend_pc_q, pend_pc_d;

    logic [IDX_W-1:0] pc_index;
    logic [OFF_W-1:0] pc_offset;
    logic [TAG_W-1:0] pc_tag;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             lookup_hit;
    logic             wr_en;
    logic             install;

    assign pc_offset  = pc_q[2 +: OFF_W];
    assign pc_index   = pc_q[2 + OFF_W +: IDX_W];
    assign pc_tag     = pc_q[31 -: TAG_W];
    assign lookup_hit = rd_valid && (rd_tag == pc_tag);

    icache_array #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .IDX_W          (IDX_W),
        .OFF_W          (OFF_W),
        .TAG_W          (TAG_W)
    ) u_array (
        .clk         (clk),
        .rst         (rst),
        .rd_index    (pc_index),
        .rd_offset   (pc_offset),
        .rd_valid    (rd_valid),
        .rd_tag      (rd_tag),
        .rd_data     (rd_data),
        .wr_en       (wr_en),
        .wr_index    (pc_index),
        .wr_offset   (cnt_q),
        .wr_data     (mem_rdata),
        .install     (install),
        .install_tag (pc_tag)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        wr_en     = 1'b0;
        install   = 1'b0;
        hit       = 1'b0;
        ins       = NOP_INSTR;
        pc_out    = pc_q;
        mem_req   = 1'b0;
        mem_addr  = '0;

        unique case (state_q)
            IDLE: begin
                hit = lookup_hit;
                if (lookup_hit) begin
                    ins = rd_data;
                end
                if (redirect) begin
                    pc_d = redirect_pc;
                end else if (!lookup_hit) begin
                    state_d = REFILL;
                    cnt_d   = '0;
                end else if (!stall) begin
                    pc_d = pc_q + 32'(WORD_BYTES);
                end
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {pc_q[31:OFF_W+2], cnt_q, 2'b00};
                // Redirects arriving mid-refill are parked; the newest target wins.
                if (redirect) begin
                    pend_d    = 1'b1;
                    pend_pc_d = redirect_pc;
                end
                if (mem_valid) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        install = 1'b1;
                        state_d = IDLE;
                        pend_d  = 1'b0;
                        if (redirect) begin
                            pc_d = redirect_pc;
                        end else if (pend_q) begin
                            pc_d = pend_pc_q;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
